// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory write port used by the program loader.
//   in_valid/in_byte/in_ready : byte stream with valid/ready handshake
//   mem_rd/mem_wn             : memory read / write enables
//   mem_address               : word address
//   mem_write_data            : instruction word to write
// master = the loader (consumes the stream, drives the memory port)
// slave  = the byte source plus the memory it writes
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24
);
  logic                  in_valid;
  logic [7:0]            in_byte;
  logic                  in_ready;
  logic                  mem_rd;
  logic                  mem_wn;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;

  modport master (
    input  in_valid, in_byte,
    output in_ready, mem_rd, mem_wn, mem_address, mem_write_data
  );

  modport slave (
    output in_valid, in_byte,
    input  in_ready, mem_rd, mem_wn, mem_address, mem_write_data
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Parses a byte stream of the form
//   len[15:8] len[7:0] | w[23:16] w[15:8] w[7:0] (x len) | xor of all data bytes
// and writes each word to consecutive addresses from 0.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse, begins a load when not busy
//   bus (master)   : byte stream in, memory write port out
//   busy           : load in progress, memory-port mux select
//   done / error   : sticky completion / failure flags, cleared by start
//   words_written  : number of words written in the current/last load
//
// state  | meaning
// IDLE   | waiting for start
// LEN_HI | take length high byte
// LEN_LO | take length low byte, range check
// B0..B2 | take word bytes, MSB first
// WRITE  | one-cycle memory write strobe
// CHK    | take checksum byte and compare
// DONE   | load finished with good checksum
// ERR    | length overflow or checksum mismatch
module imem_program_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 24,
  parameter int MEM_DEPTH  = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  imem_program_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] words_written
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, B0, B1, B2, WRITE, CHK, DONE, ERR
  } state_t;

  localparam logic [16:0] LEN_MAX = 17'(MEM_DEPTH);

  state_t                state;
  logic [7:0]            len_hi;
  logic [ADDR_WIDTH-1:0] len;
  logic [7:0]            chk;
  logic [7:0]            w_hi;
  logic [7:0]            w_mid;
  logic                  accept;
  logic [15:0]           len_next;
  logic [ADDR_WIDTH-1:0] ww_next;

  // in_ready is a pure decode of the state register, never of in_valid.
  assign bus.in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == B0) ||
                        (state == B1) || (state == B2) || (state == CHK);
  assign busy         = (state != IDLE) && (state != DONE) && (state != ERR);
  assign bus.mem_rd   = 1'b0;

  assign accept   = bus.in_valid && bus.in_ready;
  assign len_next = {len_hi, bus.in_byte};
  assign ww_next  = words_written + ADDR_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      len_hi             <= '0;
      len                <= '0;
      chk                <= '0;
      w_hi               <= '0;
      w_mid              <= '0;
      bus.mem_wn         <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      done               <= 1'b0;
      error              <= 1'b0;
      words_written      <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state           <= LEN_HI;
            done            <= 1'b0;
            error           <= 1'b0;
            words_written   <= '0;
            bus.mem_address <= '0;
            chk             <= '0;
          end else begin
            state <= IDLE;
          end
        end
        LEN_HI: begin
          if (accept) begin
            len_hi <= bus.in_byte;
            state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (accept) begin
            len <= ADDR_WIDTH'(len_next);
            if ({1'b0, len_next} > LEN_MAX) begin
              error <= 1'b1;
              state <= ERR;
            end else if (len_next == 16'd0) begin
              state <= CHK;
            end else begin
              state <= B0;
            end
          end
        end
        B0: begin
          if (accept) begin
            w_hi  <= bus.in_byte;
            chk   <= chk ^ bus.in_byte;
            state <= B1;
          end
        end
        B1: begin
          if (accept) begin
            w_mid <= bus.in_byte;
            chk   <= chk ^ bus.in_byte;
            state <= B2;
          end
        end
        B2: begin
          if (accept) begin
            bus.mem_write_data <= DATA_WIDTH'({w_hi, w_mid, bus.in_byte});
            bus.mem_wn         <= 1'b1;
            chk                <= chk ^ bus.in_byte;
            state              <= WRITE;
          end
        end
        WRITE: begin
          bus.mem_wn    <= 1'b0;
          words_written <= ww_next;
          // The address holds on the final word so it never leaves the memory range.
          if (ww_next == len) begin
            state <= CHK;
          end else begin
            bus.mem_address <= bus.mem_address + ADDR_WIDTH'(1);
            state           <= B0;
          end
        end
        CHK: begin
          if (accept) begin
            if (bus.in_byte == chk) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;
  localparam int MEM_DEPTH = 2048;

  typedef logic [7:0] u8;
  typedef struct {
    logic [15:0] a;
    logic [23:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [15:0] words_written;

  imem_program_loader_if bus_if ();

  imem_program_loader #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(24),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus_if),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  wr_t exp_q[$];
  bit  m_done, m_err;
  int  m_ww;
  u8   m_chk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: derive the expected writes and final flags straight from the
  // stream format, given how many leading bytes of the stream actually get sent.
  task automatic model_load(input u8 s[$], input int sent);
    int len;
    int base;
    logic [23:0] w;
    exp_q.delete();
    m_done = 1'b0;
    m_err  = 1'b0;
    m_ww   = 0;
    m_chk  = 8'h00;
    if (sent < 2) return;
    len = int'({s[0], s[1]});
    if (len > MEM_DEPTH) begin
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i < len; i++) begin
      base = 2 + 3 * i;
      w = {s[base], s[base+1], s[base+2]};
      m_chk = m_chk ^ s[base] ^ s[base+1] ^ s[base+2];
      if (base + 3 <= sent) begin
        exp_q.push_back('{a: 16'(i), d: w});
        m_ww++;
      end
    end
    if (sent > 2 + 3 * len) begin
      if (s[2 + 3 * len] == m_chk) m_done = 1'b1;
      else m_err = 1'b1;
    end
  endtask

  // Every cycle: memory is never read, writes match the model in order,
  // and no byte is accepted during a write cycle.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      check("mem_rd_zero", 32'(bus_if.mem_rd), 32'd0);
      if (bus_if.mem_wn) begin
        check("in_ready_low_in_write", 32'(bus_if.in_ready), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual addr=%0h data=%0h required none at %0t",
                   bus_if.mem_address, bus_if.mem_write_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(bus_if.mem_address), 32'(e.a));
          check("write_data", 32'(bus_if.mem_write_data), 32'(e.d));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers bytes [0, n) of s; a byte moves on only when seen with in_valid && in_ready.
  task automatic send(input u8 s[$], input int n, input bit drop, input int start_at);
    bit acc;
    bit v;
    bit started;
    int budget;
    started = 1'b0;
    for (int k = 0; k < n; k++) begin
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        @(negedge clk);
        v = drop ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus_if.in_valid = v;
        bus_if.in_byte  = s[k];
        start = (k == start_at) && !started;
        if (k == start_at) started = 1'b1;
        acc = v && bus_if.in_ready;
        @(posedge clk);
        budget++;
        if (!acc && budget > 100) begin
          checks++;
          failures++;
          $display("FAIL byte_timeout actual not accepted required accepted byte=%0d", k);
          @(negedge clk);
          bus_if.in_valid = 1'b0;
          start = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic finish_check(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(m_done));
    check({tag, "_error"}, 32'(error), 32'(m_err));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'(m_ww));
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    u8 s1[$];
    u8 s2[$];
    u8 s3[$];
    u8 s4[$];
    u8 s5[$];
    u8 sb[$];
    u8 c;
    bus_if.in_valid = 1'b0;
    bus_if.in_byte  = 8'h00;

    // XOR of 12 34 56 AB CD EF is 0xF9.
    s1 = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF, 8'hF9};

    // Reset values
    do_reset();
    @(negedge clk);
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("rst_mem_wn", 32'(bus_if.mem_wn), 32'd0);
    check("rst_addr", 32'(bus_if.mem_address), 32'd0);
    check("rst_data", 32'(bus_if.mem_write_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_words", 32'(words_written), 32'd0);

    // Scenario 1: two words, good checksum
    model_load(s1, s1.size());
    check("s1_model_chk", 32'(m_chk), 32'hF9);
    check("s1_model_nwr", 32'(exp_q.size()), 32'd2);
    check("s1_model_w1", 32'(exp_q[1].d), 32'hABCDEF);
    pulse_start();
    check("s1_busy_after_start", 32'(busy), 32'd1);
    check("s1_ready_len_hi", 32'(bus_if.in_ready), 32'd1);
    send(s1, s1.size(), 1'b0, -1);
    finish_check("s1");
    check("s1_done_lit", 32'(done), 32'd1);
    check("s1_words_lit", 32'(words_written), 32'd2);

    // Scenario 2: bad checksum, words still written
    s2 = s1;
    s2[8] = 8'h00;
    model_load(s2, s2.size());
    pulse_start();
    check("s2_done_cleared", 32'(done), 32'd0);
    send(s2, s2.size(), 1'b0, -1);
    finish_check("s2");
    check("s2_error_lit", 32'(error), 32'd1);

    // Scenario 3: length overflow, then zero length
    s3 = '{8'h08, 8'h01};
    model_load(s3, s3.size());
    pulse_start();
    send(s3, s3.size(), 1'b0, -1);
    check("s3_err_immediate", 32'(error), 32'd1);
    check("s3_busy_immediate", 32'(busy), 32'd0);
    finish_check("s3");
    s3 = '{8'h00, 8'h00, 8'h00};
    model_load(s3, s3.size());
    pulse_start();
    send(s3, s3.size(), 1'b0, -1);
    finish_check("s3z");
    check("s3z_done_lit", 32'(done), 32'd1);

    // Scenario 4: random stalls
    model_load(s1, s1.size());
    pulse_start();
    send(s1, s1.size(), 1'b1, -1);
    finish_check("s4");

    // Scenario 5: async reset after two bytes of the second word
    model_load(s1, 7);
    pulse_start();
    send(s1, 7, 1'b0, -1);
    check("s5_words_before", 32'(words_written), 32'(m_ww));
    check("s5_writes_done", 32'(exp_q.size()), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_busy", 32'(busy), 32'd0);
    check("s5_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("s5_mem_wn", 32'(bus_if.mem_wn), 32'd0);
    check("s5_addr", 32'(bus_if.mem_address), 32'd0);
    check("s5_data", 32'(bus_if.mem_write_data), 32'd0);
    check("s5_words", 32'(words_written), 32'd0);
    check("s5_done", 32'(done), 32'd0);
    check("s5_error", 32'(error), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    s5 = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hCD};
    model_load(s5, s5.size());
    check("s5_model_chk", 32'(m_chk), 32'hCD);
    pulse_start();
    send(s5, s5.size(), 1'b0, -1);
    finish_check("s5");

    // Scenario 6: start while in B1 is ignored; start after done restarts
    model_load(s1, s1.size());
    pulse_start();
    send(s1, s1.size(), 1'b0, 3);
    finish_check("s6");
    pulse_start();
    check("s6_done_cleared", 32'(done), 32'd0);
    check("s6_busy", 32'(busy), 32'd1);
    check("s6_ready", 32'(bus_if.in_ready), 32'd1);
    check("s6_words_cleared", 32'(words_written), 32'd0);
    s4 = '{8'h00, 8'h00, 8'h00};
    model_load(s4, s4.size());
    send(s4, s4.size(), 1'b0, -1);
    finish_check("s6z");

    // Full-depth load: len == MEM_DEPTH is legal, last address 2047
    sb.delete();
    sb.push_back(8'h08);
    sb.push_back(8'h00);
    c = 8'h00;
    for (int i = 0; i < MEM_DEPTH; i++) begin
      sb.push_back(8'(i));
      sb.push_back(8'(i >> 3));
      sb.push_back(8'(i * 7));
      c = c ^ 8'(i) ^ 8'(i >> 3) ^ 8'(i * 7);
    end
    sb.push_back(c);
    model_load(sb, sb.size());
    check("full_model_nwr", 32'(exp_q.size()), 32'd2048);
    check("full_model_last", 32'(exp_q[2047].a), 32'd2047);
    pulse_start();
    send(sb, sb.size(), 1'b0, -1);
    finish_check("full");
    check("full_words_lit", 32'(words_written), 32'd2048);
    check("full_last_addr", 32'(bus_if.mem_address), 32'd2047);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
